lab2_proc_mem_arbiter: RTL and testbench

Shares one in-order memory port between the fetch (I) and data (D) requesters of the 5-stage pipeline.
- Round-robin arbitration on the request side.
- A tag FIFO of outstanding grants routes each memory response back to the requester that issued it.
- Sits between the processor (control plus datapath) and a single-ported cache or test memory.
- All streams use val/rdy handshakes; a transfer occurs on a cycle where both val and rdy are 1.

---
 rtl/lab2_proc_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_lab2_proc_mem_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_mem_arbiter.sv
// Round-robin I/D arbiter onto one in-order memory port with a tag FIFO.
// Optional squash-drop of fetch responses: LAB2_PROC_MEM_ARB_IDROP_EN.
module lab2_proc_mem_arbiter #(
   parameter int p_max_inflight = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef LAB2_PROC_MEM_ARB_IDROP_EN
   input  logic        idrop,
`endif
   input  logic        ireq_val,
   output logic        ireq_rdy,
   input  logic [31:0] ireq_addr,
   input  logic        dreq_val,
   output logic        dreq_rdy,
   input  logic        dreq_type,
   input  logic [31:0] dreq_addr,
   input  logic [31:0] dreq_data,
   output logic        mreq_val,
   input  logic        mreq_rdy,
   output logic        mreq_type,
   output logic [31:0] mreq_addr,
   output logic [31:0] mreq_data,
   input  logic        mresp_val,
   output logic        mresp_rdy,
   input  logic [31:0] mresp_data,
   output logic        iresp_val,
   input  logic        iresp_rdy,
   output logic        dresp_val,
   input  logic        dresp_rdy,
   output logic [31:0] resp_data,
   output logic [4:0]  inflight,
   output logic        err
);

   typedef enum logic {
      TAG_I = 1'b0,
      TAG_D = 1'b1
   } tag_e;

   localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(p_max_inflight - 1);
   localparam logic [4:0] MAX_CNT = 5'(p_max_inflight);

   logic [p_max_inflight-1:0] tag_q, tag_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]    cnt_q, cnt_d;
   tag_e          last_q, last_d;
   logic          err_q, err_d;

   logic fifo_full;
   logic fifo_empty;
   logic can_issue;
   tag_e grant;
   tag_e head;
   logic push;
   logic pop;
   logic drop;

   assign fifo_full  = (cnt_q == MAX_CNT);
   assign fifo_empty = (cnt_q == 5'd0);
   assign head       = tag_e'(tag_q[rd_ptr_q]);
   assign inflight   = cnt_q;
   assign err        = err_q;

   // Request side: grant is combinational, priority comes from last_q.
   always_comb begin
      can_issue = mreq_rdy & ~fifo_full;
      grant     = TAG_I;
      if (ireq_val & dreq_val) begin
         grant = (last_q == TAG_I) ? TAG_D : TAG_I;
      end else if (dreq_val) begin
         grant = TAG_D;
      end
      mreq_val  = (ireq_val | dreq_val) & ~fifo_full;
      ireq_rdy  = (grant == TAG_I) & can_issue;
      dreq_rdy  = (grant == TAG_D) & can_issue;
      mreq_type = 1'b0;
      mreq_addr = ireq_addr;
      mreq_data = '0;
      if (grant == TAG_D) begin
         mreq_type = dreq_type;
         mreq_addr = dreq_addr;
         mreq_data = dreq_data;
      end
      push = mreq_val & mreq_rdy;
   end

   // Response side: the head tag steers the memory response.
   always_comb begin
      iresp_val = 1'b0;
      dresp_val = 1'b0;
      mresp_rdy = 1'b0;
      resp_data = mresp_data;
      if (!fifo_empty) begin
         if (drop) begin
            mresp_rdy = 1'b1;
         end else if (head == TAG_I) begin
            iresp_val = mresp_val;
            mresp_rdy = iresp_rdy;
         end else begin
            dresp_val = mresp_val;
            mresp_rdy = dresp_rdy;
         end
      end
      pop = mresp_val & mresp_rdy;
   end

   always_comb begin
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
      err_d    = err_q | (mresp_val & fifo_empty);
      if (push) begin
         tag_d[wr_ptr_q] = grant;
         wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
         last_d   = grant;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 5'd1;
         2'b01:   cnt_d = cnt_q - 5'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= TAG_I;
         err_q    <= 1'b0;
      end else begin
         tag_q    <= tag_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

`ifdef LAB2_PROC_MEM_ARB_IDROP_EN
   logic [4:0] icnt_q, icnt_d;
   logic [4:0] drop_cnt_q, drop_cnt_d;

   assign drop = (drop_cnt_q != 5'd0) & ~fifo_empty & (head == TAG_I);

   // A squash covers every fetch still owed, including one issued this cycle.
   always_comb begin
      icnt_d = icnt_q;
      if (push & (grant == TAG_I)) begin
         icnt_d = icnt_d + 5'd1;
      end
      if (pop & (head == TAG_I)) begin
         icnt_d = icnt_d - 5'd1;
      end
      drop_cnt_d = drop_cnt_q;
      if (idrop) begin
         drop_cnt_d = icnt_d;
      end else if (drop & pop) begin
         drop_cnt_d = drop_cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         icnt_q     <= '0;
         drop_cnt_q <= '0;
      end else begin
         icnt_q     <= icnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
`else
   assign drop = 1'b0;
`endif

endmodule

// File: tb/tb_lab2_proc_mem_arbiter.sv
// Bench for lab2_proc_mem_arbiter: vector table plus in-order response scoreboard.
// Squash-drop sequence only when LAB2_PROC_MEM_ARB_IDROP_EN is defined.
module tb_lab2_proc_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
`ifdef LAB2_PROC_MEM_ARB_IDROP_EN
   logic        idrop;
`endif
   logic        ireq_val, ireq_rdy;
   logic [31:0] ireq_addr;
   logic        dreq_val, dreq_rdy, dreq_type;
   logic [31:0] dreq_addr, dreq_data;
   logic        mreq_val, mreq_rdy, mreq_type;
   logic [31:0] mreq_addr, mreq_data;
   logic        mresp_val, mresp_rdy;
   logic [31:0] mresp_data;
   logic        iresp_val, iresp_rdy;
   logic        dresp_val, dresp_rdy;
   logic [31:0] resp_data;
   logic [4:0]  inflight;
   logic        err;

   always #5 clk = ~clk;

   lab2_proc_mem_arbiter #(.p_max_inflight(4)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef LAB2_PROC_MEM_ARB_IDROP_EN
      .idrop      (idrop),
`endif
      .ireq_val   (ireq_val),
      .ireq_rdy   (ireq_rdy),
      .ireq_addr  (ireq_addr),
      .dreq_val   (dreq_val),
      .dreq_rdy   (dreq_rdy),
      .dreq_type  (dreq_type),
      .dreq_addr  (dreq_addr),
      .dreq_data  (dreq_data),
      .mreq_val   (mreq_val),
      .mreq_rdy   (mreq_rdy),
      .mreq_type  (mreq_type),
      .mreq_addr  (mreq_addr),
      .mreq_data  (mreq_data),
      .mresp_val  (mresp_val),
      .mresp_rdy  (mresp_rdy),
      .mresp_data (mresp_data),
      .iresp_val  (iresp_val),
      .iresp_rdy  (iresp_rdy),
      .dresp_val  (dresp_val),
      .dresp_rdy  (dresp_rdy),
      .resp_data  (resp_data),
      .inflight   (inflight),
      .err        (err)
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   // In-order memory model, latency one cycle.
   logic        resp_en;
   logic        inject;
   logic [31:0] mem_q[$];
   int          mem_n;
   logic [31:0] mem_head;

   assign mresp_val  = inject | (resp_en & (mem_n != 0));
   assign mresp_data = mem_head;

   initial begin
      bit          tr;
      bit          tp;
      bit          rs;
      logic [31:0] ad;
      mem_n    = 0;
      mem_head = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         tr = mreq_val && mreq_rdy;
         ad = mreq_addr;
         tp = mresp_val && mresp_rdy && !inject;
         rs = reset;
         @(posedge clk);
         #1;
         if (rs) begin
            mem_q.delete();
         end else begin
            if (tp && mem_q.size() > 0) void'(mem_q.pop_front());
            if (tr) mem_q.push_back(ad);
         end
         mem_n    = mem_q.size();
         mem_head = (mem_n != 0) ? mdata(mem_q[0]) : 32'hDEAD_BEEF;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        dest;
      logic [31:0] data;
   } sb_t;
   sb_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called at the negedge: retire responses, record accepted requests.
   task automatic sb_sample();
      sb_t e;
      chk("rdy_exclusive", 32'(ireq_rdy & dreq_rdy), 32'd0);
      if (iresp_val && iresp_rdy) begin
         if (sb.size() == 0) begin
            chk("i_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("i_dest", 32'(e.dest), 32'd0);
            chk("i_data", resp_data, e.data);
         end
      end
      if (dresp_val && dresp_rdy) begin
         if (sb.size() == 0) begin
            chk("d_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("d_dest", 32'(e.dest), 32'd1);
            chk("d_data", resp_data, e.data);
         end
      end
      if (ireq_val && ireq_rdy) sb.push_back({1'b0, mdata(ireq_addr)});
      if (dreq_val && dreq_rdy) sb.push_back({1'b1, mdata(dreq_addr)});
   endtask

   task automatic post();
      sb_sample();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          ival;
      logic [31:0] iaddr;
      bit          dval;
      logic [31:0] daddr;
      bit          dtype;
      bit          men;
      bit          e_mval;
      bit          e_irdy;
      bit          e_drdy;
      logic [31:0] e_maddr;
      bit          e_iv;
      bit          e_dv;
      logic [31:0] e_data;
      logic [4:0]  e_infl;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit ival, input logic [31:0] iaddr,
                      input bit dval, input logic [31:0] daddr,
                      input bit dtype, input bit men,
                      input bit e_mval, input bit e_irdy, input bit e_drdy,
                      input logic [31:0] e_maddr,
                      input bit e_iv, input bit e_dv,
                      input logic [31:0] e_data, input logic [4:0] e_infl);
      vec_t v;
      v.ival = ival;     v.iaddr = iaddr;
      v.dval = dval;     v.daddr = daddr;
      v.dtype = dtype;   v.men = men;
      v.e_mval = e_mval; v.e_irdy = e_irdy;
      v.e_drdy = e_drdy; v.e_maddr = e_maddr;
      v.e_iv = e_iv;     v.e_dv = e_dv;
      v.e_data = e_data; v.e_infl = e_infl;
      tbl.push_back(v);
   endtask

   initial begin
      vec_t        v;
      bit          gd;
      bit          iv;
      bit          dv;
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] ed;
      sb_t         keep[$];

      reset     = 1'b1;
`ifdef LAB2_PROC_MEM_ARB_IDROP_EN
      idrop     = 1'b0;
`endif
      ireq_val  = 1'b0;
      ireq_addr = '0;
      dreq_val  = 1'b0;
      dreq_type = 1'b0;
      dreq_addr = '0;
      dreq_data = '0;
      mreq_rdy  = 1'b1;
      iresp_rdy = 1'b1;
      dresp_rdy = 1'b1;
      resp_en   = 1'b0;
      inject    = 1'b0;

      // Test 1: simultaneous D/I read after reset, D wins the tie.
      add(1, 32'h200, 1, 32'h100, 0, 1, 1, 0, 1, 32'h100, 0, 0, 0, 0);
      add(1, 32'h200, 0, 0, 0, 1, 1, 1, 0, 32'h200, 0, 1, mdata(32'h100), 1);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, mdata(32'h200), 1);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Test 2: both valid for 8 cycles; D side issues writes.
      for (int k = 0; k < 8; k++) begin
         gd = (k % 2) == 0;
         ia = 32'h2000 + 32'(4 * (k / 2));
         da = 32'h1000 + 32'(4 * ((k + 1) / 2));
         iv = 1'b0;
         dv = 1'b0;
         ed = '0;
         if (k > 0) begin
            if (((k - 1) % 2) == 0) begin
               dv = 1'b1;
               ed = mdata(32'h1000 + 32'(4 * ((k - 1) / 2)));
            end else begin
               iv = 1'b1;
               ed = mdata(32'h2000 + 32'(4 * ((k - 1) / 2)));
            end
         end
         add(1, ia, 1, da, 1, 1, 1, !gd, gd, gd ? da : ia,
             iv, dv, ed, (k == 0) ? 5'd0 : 5'd1);
      end
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, mdata(32'h200C), 1);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Test 3: fill the tag FIFO with responses withheld.
      for (int j = 0; j < 4; j++) begin
         ia = 32'h200 + 32'(4 * j);
         add(1, ia, 0, 0, 0, 0, 1, 1, 0, ia, 0, 0, 0, 5'(j));
      end
      add(1, 32'h210, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
      add(1, 32'h210, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, mdata(32'h200), 4);
      add(1, 32'h210, 0, 0, 0, 0, 1, 1, 0, 32'h210, 0, 0, 0, 3);
      for (int j = 1; j < 5; j++) begin
         add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0,
             mdata(32'h200 + 32'(4 * j)), 5'(5 - j));
      end
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mreq_val", 32'(mreq_val), 32'd0);
      chk("rst_iresp_val", 32'(iresp_val), 32'd0);
      chk("rst_dresp_val", 32'(dresp_val), 32'd0);
      post();

      foreach (tbl[n]) begin
         v = tbl[n];
         ireq_val  = v.ival;
         ireq_addr = v.iaddr;
         dreq_val  = v.dval;
         dreq_addr = v.daddr;
         dreq_type = v.dtype;
         dreq_data = v.daddr ^ 32'hFFFF_FFFF;
         resp_en   = v.men;
         @(negedge clk);
         gd = v.dval && v.e_drdy;
         chk("mreq_val", 32'(mreq_val), 32'(v.e_mval));
         if (v.ival) chk("ireq_rdy", 32'(ireq_rdy), 32'(v.e_irdy));
         if (v.dval) chk("dreq_rdy", 32'(dreq_rdy), 32'(v.e_drdy));
         if (v.e_mval) begin
            chk("mreq_addr", mreq_addr, v.e_maddr);
            chk("mreq_type", 32'(mreq_type), 32'(gd ? v.dtype : 1'b0));
            chk("mreq_data", mreq_data, gd ? dreq_data : 32'd0);
         end
         chk("iresp_val", 32'(iresp_val), 32'(v.e_iv));
         chk("dresp_val", 32'(dresp_val), 32'(v.e_dv));
         if (v.e_iv || v.e_dv) chk("resp_data", resp_data, v.e_data);
         chk("inflight", 32'(inflight), 32'(v.e_infl));
         post();
      end

      // Test 4: stalled D response blocks the I response behind it.
      ireq_val  = 1'b0;
      dreq_val  = 1'b1;
      dreq_type = 1'b0;
      dreq_addr = 32'h300;
      dreq_data = '0;
      dresp_rdy = 1'b0;
      resp_en   = 1'b1;
      @(negedge clk);
      chk("t4_dreq_rdy", 32'(dreq_rdy), 32'd1);
      post();
      dreq_val  = 1'b0;
      ireq_val  = 1'b1;
      ireq_addr = 32'h400;
      @(negedge clk);
      chk("t4_ireq_rdy", 32'(ireq_rdy), 32'd1);
      chk("t4_stall_dv", 32'(dresp_val), 32'd1);
      chk("t4_stall_mrdy", 32'(mresp_rdy), 32'd0);
      chk("t4_stall_iv", 32'(iresp_val), 32'd0);
      post();
      ireq_val = 1'b0;
      @(negedge clk);
      chk("t4_hold_dv", 32'(dresp_val), 32'd1);
      chk("t4_hold_mrdy", 32'(mresp_rdy), 32'd0);
      chk("t4_hold_iv", 32'(iresp_val), 32'd0);
      chk("t4_hold_infl", 32'(inflight), 32'd2);
      post();
      dresp_rdy = 1'b1;
      @(negedge clk);
      chk("t4_d_go", 32'(dresp_val), 32'd1);
      chk("t4_d_data", resp_data, mdata(32'h300));
      chk("t4_d_mrdy", 32'(mresp_rdy), 32'd1);
      post();
      @(negedge clk);
      chk("t4_i_go", 32'(iresp_val), 32'd1);
      chk("t4_i_dv", 32'(dresp_val), 32'd0);
      chk("t4_i_data", resp_data, mdata(32'h400));
      post();
      @(negedge clk);
      chk("t4_infl", 32'(inflight), 32'd0);
      post();

      // Test 5: unexpected response sets the sticky error.
      resp_en = 1'b0;
      inject  = 1'b1;
      @(negedge clk);
      chk("t5_mrdy", 32'(mresp_rdy), 32'd0);
      chk("t5_iv", 32'(iresp_val), 32'd0);
      chk("t5_dv", 32'(dresp_val), 32'd0);
      chk("t5_err_pre", 32'(err), 32'd0);
      post();
      inject = 1'b0;
      @(negedge clk);
      chk("t5_err_set", 32'(err), 32'd1);
      post();
      repeat (3) post();
      @(negedge clk);
      chk("t5_err_sticky", 32'(err), 32'd1);
      post();
      reset = 1'b1;
      post();
      reset = 1'b0;
      @(negedge clk);
      chk("t5_err_clr", 32'(err), 32'd0);
      chk("t5_infl_clr", 32'(inflight), 32'd0);
      post();

`ifdef LAB2_PROC_MEM_ARB_IDROP_EN
      // Test 6: squash two outstanding fetches, then fetch normally.
      resp_en   = 1'b0;
      ireq_val  = 1'b1;
      ireq_addr = 32'h500;
      post();
      ireq_addr = 32'h504;
      post();
      ireq_val = 1'b0;
      idrop    = 1'b1;
      @(negedge clk);
      chk("t6_infl", 32'(inflight), 32'd2);
      post();
      keep.delete();
      foreach (sb[n]) if (sb[n].dest) keep.push_back(sb[n]);
      sb = keep;
      idrop   = 1'b0;
      resp_en = 1'b1;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         chk("t6_drop_iv", 32'(iresp_val), 32'd0);
         chk("t6_drop_mrdy", 32'(mresp_rdy), 32'd1);
         post();
      end
      ireq_val  = 1'b1;
      ireq_addr = 32'h300;
      @(negedge clk);
      chk("t6_drained", 32'(inflight), 32'd0);
      post();
      ireq_val = 1'b0;
      @(negedge clk);
      chk("t6_fetch_iv", 32'(iresp_val), 32'd1);
      chk("t6_fetch_data", resp_data, mdata(32'h300));
      post();
      @(negedge clk);
      chk("t6_infl_end", 32'(inflight), 32'd0);
      post();
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
